// File: rtl/ppu_pkg.sv
// Shared PPU-side definitions: register indices, the $4014 trigger address
// and the sprite-DMA state encoding.
package ppu_pkg;

    localparam logic [2:0] PPUCTRL   = 3'd0;
    localparam logic [2:0] PPUMASK   = 3'd1;
    localparam logic [2:0] PPUSTATUS = 3'd2;
    localparam logic [2:0] OAMADDR   = 3'd3;
    localparam logic [2:0] OAMDATA   = 3'd4;
    localparam logic [2:0] PPUSCROLL = 3'd5;
    localparam logic [2:0] PPUADDR   = 3'd6;
    localparam logic [2:0] PPUDATA   = 3'd7;

    localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_READ,
        S_WAIT,
        S_STROBE_LO,
        S_STROBE_HI,
        S_DONE
    } dma_state_e;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: a $4014 write stalls the CPU and copies page $PP00-$PPFF into
// OAMDATA, one chip-select strobe per byte. All outputs are registered.
module oam_dma
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_ADDR       = OAM_DMA_ADDR,
    parameter int          CS_LOW_CYCLES  = 2,
    parameter int          CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        ppu_cs_n,
    output logic        ppu_we,
    output logic [2:0]  ppu_reg_addr,
    output logic [7:0]  ppu_wdata
);

    localparam int CNT_MAX = (CS_LOW_CYCLES > CS_HIGH_CYCLES) ? CS_LOW_CYCLES : CS_HIGH_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LO_LOAD = CW'(CS_LOW_CYCLES - 1);
    localparam logic [CW-1:0] HI_LOAD = CW'(CS_HIGH_CYCLES - 1);

    dma_state_e    state_q, state_d;
    logic [7:0]    page_q, page_d;
    logic [7:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          cpu_rdy_q, cpu_rdy_d;
    logic          dma_busy_q, dma_busy_d;
    logic          mem_rd_q, mem_rd_d;
    logic [15:0]   mem_addr_q, mem_addr_d;
    logic          ppu_cs_n_q, ppu_cs_n_d;
    logic          ppu_we_q, ppu_we_d;
    logic [2:0]    ppu_reg_addr_q, ppu_reg_addr_d;
    logic [7:0]    ppu_wdata_q, ppu_wdata_d;

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_wr && cpu_addr == DMA_ADDR) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'd0;
                    state_d = S_HALT;
                end
            end
            S_HALT: state_d = S_READ;
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_STROBE_LO;
                cnt_d   = LO_LOAD;
            end
            S_STROBE_LO: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE_HI;
                    cnt_d   = HI_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE_HI: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_comb begin
        cpu_rdy_d      = (state_d == S_IDLE);
        dma_busy_d     = (state_d != S_IDLE);
        mem_rd_d       = (state_d == S_READ);
        mem_addr_d     = (state_d == S_READ) ? {page_d, idx_d} : mem_addr_q;
        ppu_cs_n_d     = (state_d != S_STROBE_LO);
        ppu_we_d       = (state_d == S_STROBE_LO);
        ppu_reg_addr_d = ppu_reg_addr_q;
        if (state_d == S_STROBE_LO) begin
            ppu_reg_addr_d = OAMDATA;
        end else if (state_d == S_IDLE) begin
            ppu_reg_addr_d = 3'd0;
        end
        ppu_wdata_d    = (state_q == S_WAIT) ? mem_rdata : ppu_wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            page_q         <= 8'd0;
            idx_q          <= 8'd0;
            cnt_q          <= '0;
            cpu_rdy_q      <= 1'b1;
            dma_busy_q     <= 1'b0;
            mem_rd_q       <= 1'b0;
            mem_addr_q     <= 16'd0;
            ppu_cs_n_q     <= 1'b1;
            ppu_we_q       <= 1'b0;
            ppu_reg_addr_q <= 3'd0;
            ppu_wdata_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            page_q         <= page_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            cpu_rdy_q      <= cpu_rdy_d;
            dma_busy_q     <= dma_busy_d;
            mem_rd_q       <= mem_rd_d;
            mem_addr_q     <= mem_addr_d;
            ppu_cs_n_q     <= ppu_cs_n_d;
            ppu_we_q       <= ppu_we_d;
            ppu_reg_addr_q <= ppu_reg_addr_d;
            ppu_wdata_q    <= ppu_wdata_d;
        end
    end

    assign cpu_rdy      = cpu_rdy_q;
    assign dma_busy     = dma_busy_q;
    assign mem_rd       = mem_rd_q;
    assign mem_addr     = mem_addr_q;
    assign ppu_cs_n     = ppu_cs_n_q;
    assign ppu_we       = ppu_we_q;
    assign ppu_reg_addr = ppu_reg_addr_q;
    assign ppu_wdata    = ppu_wdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: default-timing instance (a_*) plus a CS 1/3 instance (b_*),
// both against a shared byte-array memory and OAMDATA write logs.
module tb_oam_dma;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:65535];

    // Instance A: default strobe timing
    logic        rst_a, a_cpu_wr, a_cpu_rdy, a_busy, a_mem_rd, a_cs_n, a_we;
    logic [15:0] a_cpu_addr, a_mem_addr;
    logic [7:0]  a_cpu_wdata, a_mem_rdata, a_wdata;
    logic [2:0]  a_reg_addr;

    oam_dma u_a (
        .clk(clk), .reset(rst_a), .cpu_wr(a_cpu_wr), .cpu_addr(a_cpu_addr),
        .cpu_wdata(a_cpu_wdata), .cpu_rdy(a_cpu_rdy), .dma_busy(a_busy),
        .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_rdata(a_mem_rdata),
        .ppu_cs_n(a_cs_n), .ppu_we(a_we), .ppu_reg_addr(a_reg_addr), .ppu_wdata(a_wdata)
    );

    // Instance B: CS low 1, high 3
    logic        rst_b, b_cpu_wr, b_cpu_rdy, b_busy, b_mem_rd, b_cs_n, b_we;
    logic [15:0] b_cpu_addr, b_mem_addr;
    logic [7:0]  b_cpu_wdata, b_mem_rdata, b_wdata;
    logic [2:0]  b_reg_addr;

    oam_dma #(.CS_LOW_CYCLES(1), .CS_HIGH_CYCLES(3)) u_b (
        .clk(clk), .reset(rst_b), .cpu_wr(b_cpu_wr), .cpu_addr(b_cpu_addr),
        .cpu_wdata(b_cpu_wdata), .cpu_rdy(b_cpu_rdy), .dma_busy(b_busy),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
        .ppu_cs_n(b_cs_n), .ppu_we(b_we), .ppu_reg_addr(b_reg_addr), .ppu_wdata(b_wdata)
    );

    // Work RAM: data valid the cycle after the read request
    always @(posedge clk) begin
        if (a_mem_rd) a_mem_rdata <= mem[a_mem_addr];
        if (b_mem_rd) b_mem_rdata <= mem[b_mem_addr];
    end

    // Observation logs (sampled on the falling edge)
    logic [15:0] a_rd_q[$], b_rd_q[$];
    logic [7:0]  a_wd_q[$], b_wd_q[$];
    logic [2:0]  a_ra_q[$], b_ra_q[$];
    int          a_len_q[$], b_len_q[$];
    int          a_rdy_low = 0, b_rdy_low = 0;
    int          a_low_len = 0, b_low_len = 0;
    logic        a_prev_cs = 1'b1, b_prev_cs = 1'b1;

    always @(negedge clk) begin
        if (a_mem_rd === 1'b1) a_rd_q.push_back(a_mem_addr);
        if (a_prev_cs === 1'b1 && a_cs_n === 1'b0) begin
            a_wd_q.push_back(a_wdata);
            a_ra_q.push_back(a_reg_addr);
            a_low_len = 1;
        end else if (a_cs_n === 1'b0) begin
            a_low_len++;
        end
        if (a_prev_cs === 1'b0 && a_cs_n === 1'b1) a_len_q.push_back(a_low_len);
        if (a_cpu_rdy === 1'b0) a_rdy_low++;
        a_prev_cs = a_cs_n;

        if (b_mem_rd === 1'b1) b_rd_q.push_back(b_mem_addr);
        if (b_prev_cs === 1'b1 && b_cs_n === 1'b0) begin
            b_wd_q.push_back(b_wdata);
            b_ra_q.push_back(b_reg_addr);
            b_low_len = 1;
        end else if (b_cs_n === 1'b0) begin
            b_low_len++;
        end
        if (b_prev_cs === 1'b0 && b_cs_n === 1'b1) b_len_q.push_back(b_low_len);
        if (b_cpu_rdy === 1'b0) b_rdy_low++;
        b_prev_cs = b_cs_n;
    end

    // Reference model: a transfer of page p reads {p,i} for i=0..255 in order
    // and writes mem[{p,i}] to register 4.
    function automatic int addr_errs(input int base, input logic [7:0] page);
        int e = 0;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] ea;
            ea = {page, i[7:0]};
            if (base + i >= a_rd_q.size()) e++;
            else if (a_rd_q[base + i] !== ea) e++;
        end
        return e;
    endfunction

    function automatic int wr_errs(input int base, input logic [7:0] page);
        int e = 0;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] ea;
            ea = {page, i[7:0]};
            if (base + i >= a_wd_q.size()) e++;
            else if (a_wd_q[base + i] !== mem[ea] || a_ra_q[base + i] !== 3'd4) e++;
        end
        return e;
    endfunction

    task automatic clear_a();
        a_rd_q.delete(); a_wd_q.delete(); a_ra_q.delete(); a_len_q.delete();
        a_rdy_low = 0;
    endtask

    // Drive a one-cycle CPU write; call away from the rising edge.
    task automatic write_a(input logic [15:0] addr, input logic [7:0] data);
        a_cpu_wr = 1'b1; a_cpu_addr = addr; a_cpu_wdata = data;
        @(posedge clk); #1;
        a_cpu_wr = 1'b0; a_cpu_addr = 16'h0000; a_cpu_wdata = 8'h00;
    endtask

    // Returns at the falling edge of the first cycle with cpu_rdy high again.
    task automatic wait_done_a(output bit to);
        int n;
        to = 1'b0;
        n  = 0;
        @(negedge clk);
        while (a_cpu_rdy === 1'b1 && n < 8) begin @(negedge clk); n++; end
        if (n >= 8) begin to = 1'b1; return; end
        n = 0;
        while (a_cpu_rdy !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        if (n >= 4000) to = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        #1; rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        total += 8;
        if (a_cpu_rdy !== 1'b1)   begin bad++; $display("FAIL rst_cpu_rdy got=%b exp=1", a_cpu_rdy); end
        if (a_busy !== 1'b0)      begin bad++; $display("FAIL rst_dma_busy got=%b exp=0", a_busy); end
        if (a_mem_rd !== 1'b0)    begin bad++; $display("FAIL rst_mem_rd got=%b exp=0", a_mem_rd); end
        if (a_mem_addr !== 16'h0) begin bad++; $display("FAIL rst_mem_addr got=%h exp=0000", a_mem_addr); end
        if (a_cs_n !== 1'b1)      begin bad++; $display("FAIL rst_cs_n got=%b exp=1", a_cs_n); end
        if (a_we !== 1'b0)        begin bad++; $display("FAIL rst_we got=%b exp=0", a_we); end
        if (a_reg_addr !== 3'd0)  begin bad++; $display("FAIL rst_reg_addr got=%0d exp=0", a_reg_addr); end
        if (a_wdata !== 8'h00)    begin bad++; $display("FAIL rst_wdata got=%h exp=00", a_wdata); end
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if ({a_cpu_rdy, a_cs_n, a_mem_rd} !== 3'b110) begin
                bad++;
                $display("FAIL idle_cycle%0d rdy/cs_n/mem_rd got=%b exp=110", c, {a_cpu_rdy, a_cs_n, a_mem_rd});
            end
        end
    endtask

    task automatic test_basic();
        bit to;
        int le;
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = i[7:0] ^ 8'hA5;
        clear_a();
        #2;
        write_a(16'h4014, 8'h02);
        wait_done_a(to);
        le = 0;
        foreach (a_len_q[k]) if (a_len_q[k] != 2) le++;
        total += 7;
        if (to)                  begin bad++; $display("FAIL basic_timeout got=expired exp=done"); end
        if (a_rd_q.size() != 256) begin bad++; $display("FAIL basic_rd_count got=%0d exp=256", a_rd_q.size()); end
        if (addr_errs(0, 8'h02) != 0) begin bad++; $display("FAIL basic_addr_seq bad_entries=%0d exp=0", addr_errs(0, 8'h02)); end
        if (a_wd_q.size() != 256) begin bad++; $display("FAIL basic_wr_count got=%0d exp=256", a_wd_q.size()); end
        if (wr_errs(0, 8'h02) != 0) begin bad++; $display("FAIL basic_wr_data bad_entries=%0d exp=0", wr_errs(0, 8'h02)); end
        if (le != 0 || a_len_q.size() != 256) begin bad++; $display("FAIL basic_cs_low_len bad=%0d n=%0d exp 256 x 2", le, a_len_q.size()); end
        if (a_rdy_low != 1538)   begin bad++; $display("FAIL basic_stall_len got=%0d exp=1538", a_rdy_low); end
    endtask

    task automatic test_random_pages();
        bit to;
        logic [7:0] p;
        for (int r = 0; r < 2; r++) begin
            p = 8'($urandom_range(0, 255));
            clear_a();
            write_a(16'h4014, p);
            wait_done_a(to);
            total += 3;
            if (to || a_rdy_low != 1538) begin bad++; $display("FAIL rnd%0d_stall got=%0d to=%0b exp=1538", r, a_rdy_low, to); end
            if (addr_errs(0, p) != 0 || a_rd_q.size() != 256) begin bad++; $display("FAIL rnd%0d_addr page=%h bad=%0d n=%0d", r, p, addr_errs(0, p), a_rd_q.size()); end
            if (wr_errs(0, p) != 0 || a_wd_q.size() != 256) begin bad++; $display("FAIL rnd%0d_data page=%h bad=%0d n=%0d", r, p, wr_errs(0, p), a_wd_q.size()); end
        end
    endtask

    task automatic test_ignored();
        bit to;
        logic [7:0] p;
        p = 8'($urandom_range(0, 254));
        write_a(16'h4015, 8'h07);
        repeat (3) @(negedge clk);
        total++;
        if (a_cpu_rdy !== 1'b1 || a_mem_rd !== 1'b0) begin bad++; $display("FAIL ign_4015_idle rdy=%b mem_rd=%b exp 1/0", a_cpu_rdy, a_mem_rd); end
        #2;
        clear_a();
        write_a(16'h4014, p);
        repeat ($urandom_range(20, 700)) @(negedge clk);
        #2;
        write_a(16'h4014, p + 8'd1);
        repeat ($urandom_range(5, 200)) @(negedge clk);
        #2;
        write_a(16'h4015, 8'h55);
        wait_done_a(to);
        total += 3;
        if (to || a_rdy_low != 1538) begin bad++; $display("FAIL ign_stall got=%0d to=%0b exp=1538", a_rdy_low, to); end
        if (addr_errs(0, p) != 0 || a_rd_q.size() != 256) begin bad++; $display("FAIL ign_addr page=%h bad=%0d n=%0d exp=0/256", p, addr_errs(0, p), a_rd_q.size()); end
        if (a_wd_q.size() != 256) begin bad++; $display("FAIL ign_wr_count got=%0d exp=256", a_wd_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n;
        logic [7:0] p;
        p = 8'($urandom_range(0, 255));
        clear_a();
        write_a(16'h4014, p);
        n = 0;
        while (a_wd_q.size() < 101 && n < 3000) begin @(negedge clk); #2; n++; end
        total++;
        if (n >= 3000 || a_cs_n !== 1'b0) begin bad++; $display("FAIL rmid_reach_byte100 cs_n=%b writes=%0d exp strobe at 101", a_cs_n, a_wd_q.size()); end
        rst_a = 1'b1;
        #1;
        total += 3;
        if (a_cs_n !== 1'b1)    begin bad++; $display("FAIL rmid_cs_n got=%b exp=1", a_cs_n); end
        if (a_cpu_rdy !== 1'b1) begin bad++; $display("FAIL rmid_cpu_rdy got=%b exp=1", a_cpu_rdy); end
        if (a_busy !== 1'b0 || a_we !== 1'b0) begin bad++; $display("FAIL rmid_busy_we got=%b%b exp=00", a_busy, a_we); end
        @(posedge clk); #1;
        rst_a = 1'b0;
        n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (a_cpu_rdy !== 1'b1 || a_mem_rd !== 1'b0 || a_cs_n !== 1'b1) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("FAIL rmid_no_resume bad_cycles=%0d exp=0", n); end
        #2;
        clear_a();
        write_a(16'h4014, 8'h00);
        wait_done_a(to);
        total += 2;
        if (to || a_rd_q.size() == 0 || a_rd_q[0] !== 16'h0000) begin bad++; $display("FAIL rmid_restart_first got=%h n=%0d exp=0000", (a_rd_q.size() != 0) ? a_rd_q[0] : 16'hxxxx, a_rd_q.size()); end
        if (addr_errs(0, 8'h00) != 0 || wr_errs(0, 8'h00) != 0 || a_wd_q.size() != 256) begin bad++; $display("FAIL rmid_restart_seq addr_bad=%0d data_bad=%0d n=%0d", addr_errs(0, 8'h00), wr_errs(0, 8'h00), a_wd_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit to1, to2;
        logic [7:0] p1, p2;
        p1 = 8'($urandom_range(0, 255));
        p2 = 8'($urandom_range(0, 255));
        clear_a();
        write_a(16'h4014, p1);
        wait_done_a(to1);
        write_a(16'h4014, p2);
        wait_done_a(to2);
        total += 4;
        if (to1 || to2) begin bad++; $display("FAIL b2b_timeout got=%0b%0b exp=00", to1, to2); end
        if (a_wd_q.size() != 512) begin bad++; $display("FAIL b2b_falls got=%0d exp=512", a_wd_q.size()); end
        if (addr_errs(0, p1) != 0 || addr_errs(256, p2) != 0) begin bad++; $display("FAIL b2b_addr p1=%h bad=%0d p2=%h bad=%0d", p1, addr_errs(0, p1), p2, addr_errs(256, p2)); end
        if (a_rdy_low != 3076) begin bad++; $display("FAIL b2b_stall got=%0d exp=3076", a_rdy_low); end
    endtask

    task automatic test_page_ff();
        int n, zero_hits, ae, de, le;
        b_rd_q.delete(); b_wd_q.delete(); b_ra_q.delete(); b_len_q.delete();
        b_rdy_low = 0;
        #2;
        b_cpu_wr = 1'b1; b_cpu_addr = 16'h4014; b_cpu_wdata = 8'hFF;
        @(posedge clk); #1;
        b_cpu_wr = 1'b0; b_cpu_addr = 16'h0000;
        n = 0;
        @(negedge clk);
        while (b_cpu_rdy !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        #2;
        zero_hits = 0; ae = 0; de = 0; le = 0;
        foreach (b_rd_q[k]) begin
            if (b_rd_q[k] === 16'h0000) zero_hits++;
            if (b_rd_q[k] !== (16'hFF00 + 16'(k))) ae++;
        end
        foreach (b_wd_q[k]) if (b_wd_q[k] !== mem[16'hFF00 + 16'(k)] || b_ra_q[k] !== 3'd4) de++;
        foreach (b_len_q[k]) if (b_len_q[k] != 1) le++;
        total += 7;
        if (n >= 4000 || b_rdy_low != 1538) begin bad++; $display("FAIL ff_stall got=%0d exp=1538", b_rdy_low); end
        if (b_rd_q.size() != 256 || ae != 0) begin bad++; $display("FAIL ff_addr_seq n=%0d bad=%0d exp=256/0", b_rd_q.size(), ae); end
        if (b_rd_q.size() == 0 || b_rd_q[b_rd_q.size() - 1] !== 16'hFFFF) begin bad++; $display("FAIL ff_last_addr got=%h exp=ffff", (b_rd_q.size() != 0) ? b_rd_q[b_rd_q.size() - 1] : 16'hxxxx); end
        if (zero_hits != 0) begin bad++; $display("FAIL ff_no_wrap got=%0d exp=0", zero_hits); end
        if (b_wd_q.size() != 256 || de != 0) begin bad++; $display("FAIL ff_wr_data n=%0d bad=%0d exp=256/0", b_wd_q.size(), de); end
        if (b_len_q.size() != 256 || le != 0) begin bad++; $display("FAIL ff_cs_low_len n=%0d bad=%0d exp 256 x 1", b_len_q.size(), le); end
        if (b_reg_addr !== 3'd0 || b_cs_n !== 1'b1) begin bad++; $display("FAIL ff_idle_regs reg=%0d cs_n=%b exp=0/1", b_reg_addr, b_cs_n); end
    endtask

    initial begin
        a_cpu_wr = 1'b0; a_cpu_addr = 16'h0; a_cpu_wdata = 8'h0;
        b_cpu_wr = 1'b0; b_cpu_addr = 16'h0; b_cpu_wdata = 8'h0;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int k = 0; k < 65536; k++) mem[k] = 8'($urandom);
        test_reset();
        test_basic();
        test_random_pages();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        test_page_ff();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
